// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its event FIFO.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    SETTLE,
    DEBOUNCE,
    PUSH,
    WAIT_RELEASE
  } scan_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int key_code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead event FIFO: head always presents the oldest entry; a pop on empty is ignored.
// A push while full only lands when a pop frees a slot in the same cycle.
module keypad_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner: column strobing, 2-flop row sync, debounce, event FIFO.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner_fifo import keypad_pkg::*; #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  localparam int KW = key_code_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                key_valid,
  output logic [KW-1:0]       key_code,
  input  logic                key_ack,
  output logic                key_held,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int RW = $clog2(NUM_ROWS);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES + 1);
  localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

  if (NUM_ROWS < 2 || NUM_ROWS > 8 || NUM_COLS < 2 || NUM_COLS > 8 ||
      DEBOUNCE_CYCLES < 1 || SETTLE_CYCLES < 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("keypad_scanner_fifo: parameter out of range");
  end

  logic [NUM_ROWS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_ROWS-1:0] row_s;

  scan_state_t state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [CW-1:0] col_idx, col_n, col_next;
  logic [RW-1:0] row_lat, row_lat_n, win_row;
  logic          press_any;
  logic          press_push;
  logic          push_req;
  logic [KW-1:0] push_code;
  logic          fifo_empty;
  logic          fifo_full;
  logic          ovf_event;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= row_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    row_s     = sync_q[SYNC_STAGES-1];
    press_any = ~&row_s;
    win_row   = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) win_row = RW'(r);
    end
    col_next  = (col_idx == CW'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
    push_code = KW'(int'(row_lat) * NUM_COLS + int'(col_idx));
    col_out   = ~(NUM_COLS'(1) << col_idx);
    key_held  = (state == WAIT_RELEASE);
  end

  // One counter serves settle, press debounce and release debounce; they never overlap.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    col_n      = col_idx;
    row_lat_n  = row_lat;
    press_push = 1'b0;
    case (state)
      SCAN: begin
        state_n = SETTLE;
        cnt_n   = '0;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n = '0;
          if (press_any) begin
            state_n   = DEBOUNCE;
            row_lat_n = win_row;
          end else begin
            col_n = col_next;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_s[row_lat]) begin
          if (cnt == DEB_LAST) begin
            state_n = PUSH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          state_n = SETTLE;
          col_n   = col_next;
          cnt_n   = '0;
        end
      end
      PUSH: begin
        press_push = 1'b1;
        state_n    = WAIT_RELEASE;
        cnt_n      = '0;
      end
      WAIT_RELEASE: begin
        if (press_any) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = SETTLE;
          col_n   = col_next;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state   <= SCAN;
      cnt     <= '0;
      col_idx <= '0;
      row_lat <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col_idx <= col_n;
      row_lat <= row_lat_n;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] hold_cnt;
  logic        rep_armed;
  logic        rep_push;

  always_comb begin
    rep_push = (state == WAIT_RELEASE) && press_any &&
               (hold_cnt == (rep_armed ? 16'(REPEAT_PERIOD - 1) : 16'(REPEAT_DELAY - 1)));
    push_req = press_push | rep_push;
  end

  // Any high sample (release debouncing in progress) restarts the hold timing.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hold_cnt  <= '0;
      rep_armed <= 1'b0;
    end else if (state != WAIT_RELEASE || !press_any) begin
      hold_cnt  <= '0;
      rep_armed <= 1'b0;
    end else if (rep_push) begin
      hold_cnt  <= '0;
      rep_armed <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  always_comb push_req = press_push;
`endif

  // Valid/ack: key_code is meaningful while key_valid=1; key_ack pops on the clock edge.
  keypad_event_fifo #(
    .WIDTH(KW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nRST     (nRST),
    .push     (push_req),
    .push_data(push_code),
    .pop      (key_ack),
    .head     (key_code),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    key_valid = ~fifo_empty;
    ovf_event = push_req & fifo_full & ~(key_ack & key_valid);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)             overflow <= 1'b0;
    else if (ovf_event)    overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Bench for keypad_scanner_fifo: a simulated key matrix drives the rows, a queue models the FIFO.
module tb_keypad_scanner_fifo;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  logic [3:0] kd [4];
  logic [3:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  keypad_scanner_fifo dut (
    .clk         (clk),
    .nRST        (nRST),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  // A closed switch connects its row to its column; the row reads low only when that column is strobed.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(kd[r] & ~col_out);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] code);
    if (exp_q.size() < 4) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_held(input string tag, input logic level);
    int i = 0;
    while (key_held !== level && i < 200) begin
      step(1);
      i++;
    end
    chk(tag, key_held, level);
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    kd[r][c] = 1'b1;
    wait_held("held_rise", 1'b1);
    model_push(4'(r * 4 + c));
    step(hold);
    kd[r][c] = 1'b0;
    wait_held("held_fall", 1'b0);
    step(2);
  endtask

  task automatic pop_check();
    chk("pop_valid", key_valid, 1'b1);
    chk("pop_code", key_code, exp_q[0]);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_check();
    chk("drain_empty", key_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    for (int r = 0; r < 4; r++) kd[r] = 4'b0000;

    // Reset values
    step(3);
    chk("rst_col_out", col_out, 4'b1110);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_code", key_code, 4'd0);
    chk("rst_key_held", key_held, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    nRST = 1'b1;
    step(2);

    // Clean press row1/col2, held 40 cycles
    kd[1][2] = 1'b1;
    i = 0;
    while (!key_valid && i < 60) begin
      step(1);
      i++;
    end
    chk("clean_valid_rise", key_valid, 1'b1);
    chk("clean_code", key_code, 4'd6);
    chk("clean_held", key_held, 1'b1);
    model_push(4'd6);
    pop_check();
    chk("clean_valid_after_ack", key_valid, 1'b0);
    step(40 - i);
    kd[1][2] = 1'b0;
    wait_held("clean_held_fall", 1'b0);
    step(2);
    chk("clean_one_entry", key_valid, 1'b0);

    // Bouncing press on row0/col3, then stable
    for (int b = 0; b < 7; b++) begin
      kd[0][3] = ~kd[0][3];
      step(3);
      chk("bounce_no_push", key_valid, 1'b0);
    end
    kd[0][3] = 1'b1;
    wait_held("bounce_held", 1'b1);
    model_push(4'd3);
    step(20);
    kd[0][3] = 1'b0;
    wait_held("bounce_release", 1'b0);
    step(2);
    pop_check();
    chk("bounce_single", key_valid, 1'b0);

    // Rows 0 and 2 both low on col1: lowest row wins
    kd[0][1] = 1'b1;
    kd[2][1] = 1'b1;
    wait_held("multi_held", 1'b1);
    model_push(4'd1);
    step(15);
    kd[0][1] = 1'b0;
    kd[2][1] = 1'b0;
    wait_held("multi_release", 1'b0);
    step(2);
    pop_check();

    // Another column pressed while a key is held is ignored
    kd[0][0] = 1'b1;
    wait_held("roll_held", 1'b1);
    model_push(4'd0);
    step(10);
    kd[1][3] = 1'b1;
    step(10);
    kd[1][3] = 1'b0;
    step(10);
    kd[0][0] = 1'b0;
    wait_held("roll_release", 1'b0);
    step(20);
    pop_check();
    chk("roll_single", key_valid, 1'b0);

    // Ack while empty is ignored
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    chk("ack_empty", key_valid, 1'b0);

    // Five presses without ack: first four kept, overflow set
    press_release(0, 1, 12);
    press_release(1, 0, 12);
    press_release(2, 2, 12);
    press_release(3, 3, 12);
    chk("ovf_not_yet", overflow, 1'b0);
    press_release(3, 0, 12);
    chk("ovf_set", overflow, exp_ovf);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full FIFO: push and ack on the same edge
    kd[2][3] = 1'b1;
    i = 0;
    while (dut.state != PUSH && i < 200) begin
      step(1);
      i++;
    end
    chk("full_push_seen", dut.state == PUSH, 1'b1);
    chk("full_head_before", key_code, exp_q[0]);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(4'd11);
    chk("full_no_ovf", overflow, 1'b0);
    chk("full_head_advanced", key_code, exp_q[0]);
    kd[2][3] = 1'b0;
    wait_held("full_release", 1'b0);
    step(2);
    chk("full_count_4", exp_q.size(), 4);
    drain();

    // Randomized presses with occasional acks
    for (int n = 0; n < 8; n++) begin
      press_release($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(12, 40));
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_check();
    end
    chk("rand_ovf", overflow, exp_ovf);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    drain();

    // Async reset in the middle of debounce
    press_release(1, 1, 12);
    kd[3][2] = 1'b1;
    i = 0;
    while (dut.state != DEBOUNCE && i < 100) begin
      step(1);
      i++;
    end
    chk("rst_debounce_seen", dut.state == DEBOUNCE, 1'b1);
    step(3);
    nRST = 1'b0;
    #1;
    chk("midrst_col_out", col_out, 4'b1110);
    chk("midrst_key_valid", key_valid, 1'b0);
    chk("midrst_key_code", key_code, 4'd0);
    chk("midrst_key_held", key_held, 1'b0);
    exp_q.delete();
    kd[3][2] = 1'b0;
    step(3);
    nRST = 1'b1;
    step(30);
    chk("post_rst_empty", key_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_fifo.md
Name: keypad_scanner_fifo

Overview:
Parametrised matrix-keypad scanner for the calculator front end. It drives NUM_COLS active-low column strobes and reads NUM_ROWS pulled-up rows through a synchroniser. Each key is debounced, encoded as a linear index, and pushed into a small event FIFO. The general controller drains the FIFO through a valid/ack handshake, so no key press is lost while the controller is busy.

Parameters:
NUM_ROWS, 4, number of keypad rows (2..8)
NUM_COLS, 4, number of keypad columns (2..8)
SETTLE_CYCLES, 2, extra cycles a column is driven before sampling (on top of the 2-flop sync delay)
DEBOUNCE_CYCLES, 10, consecutive stable cycles required for press and for release (>=1)
FIFO_DEPTH, 4, key event FIFO entries (power of 2, >=2)
REPEAT_DELAY, 500, cycles held before the first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_PERIOD, 100, cycles between later repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  in  1  clock
nRST  in  1  async active-low reset
row_in  in  NUM_ROWS  raw keypad rows, active low, asynchronous
col_out  out  NUM_COLS  column strobes; exactly one bit low while scanning
key_valid  out  1  FIFO non-empty; key_code valid
key_code  out  KW=$clog2(NUM_ROWS*NUM_COLS)  head entry, row*NUM_COLS+col
key_ack  in  1  pop head; ignored when key_valid=0
key_held  out  1  high in WAIT_RELEASE (key is down and debounced)
overflow  out  1  sticky; a press was dropped because the FIFO was full
overflow_clr  in  1  clears overflow

Behaviour:
- Clock and reset: clk; reset nRST, asynchronous, active-low.
- Reset values:
  - state=SCAN, col_idx=0, col_out=~1 (bit0 low).
  - FIFO empty; key_valid=0, key_code=0.
  - key_held=0, overflow=0, sync flops=all 1s.
- Synchroniser: row_in passes through 2 flops to give row_s. All decisions use row_s.
- Press detection: any row_s bit 0. If several rows are low, the lowest row index wins.
- States: SCAN, SETTLE, DEBOUNCE, PUSH, WAIT_RELEASE.
- SETTLE: drive col_idx for SETTLE_CYCLES+2 cycles, then sample row_s on the last cycle.
  - Press seen: go to DEBOUNCE with the column held; latch row_lat=winning row.
  - No press: col_idx wraps NUM_COLS-1 to 0, then SETTLE again (SCAN is a one-cycle entry state).
- DEBOUNCE:
  - Counter increments each cycle while row_s[row_lat]==0.
  - Any high sample returns to SETTLE on the next column.
  - When the counter reaches DEBOUNCE_CYCLES, go to PUSH.
- PUSH: one cycle. Writes row_lat*NUM_COLS+col_idx into the FIFO, then goes to WAIT_RELEASE.
- WAIT_RELEASE:
  - Column is held; key_held=1.
  - Requires all row_s high for DEBOUNCE_CYCLES consecutive cycles; any low sample restarts the count.
  - On release, advance col_idx and go to SETTLE.
- Latency: key_valid rises the cycle after PUSH. A clean press is sampled in SETTLE and reaches key_valid DEBOUNCE_CYCLES+2 cycles later.
- FIFO: show-ahead.
  - key_code always shows the head entry; key_ack with key_valid pops on the clock edge.
  - Push when full is dropped and sets overflow; FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the pop is ignored and the push lands.
  - overflow_clr and an overflow event in the same cycle: overflow stays 1.
- Async reset mid-scan or mid-debounce: everything returns to reset values immediately; FIFO contents are discarded.
- Keys pressed on other columns during WAIT_RELEASE are ignored (no rollover).

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in WAIT_RELEASE, a hold counter starts at entry.
  - After REPEAT_DELAY cycles the same key_code is pushed again, then again every REPEAT_PERIOD cycles while held.
  - Repeat pushes obey the same overflow rules.
  - Release debouncing resets the hold counter.
- Undefined: exactly one push per press; REPEAT_* parameters are unused and no repeat logic is synthesised.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum (SCAN, SETTLE, DEBOUNCE, PUSH, WAIT_RELEASE);
  - the sync stage constant SYNC_STAGES=2;
  - a function key_code_width(rows, cols).
- Sub-module keypad_event_fifo: parameters WIDTH, DEPTH; ports push, push_data, pop, head, empty, full. It is reusable by later UART input.

Test Plan (all default parameters):
- Clean press of row1 with col2 low, held 40 cycles then released -> key_valid rises, key_code=6; after key_ack, key_valid=0; exactly one entry.
- Press bouncing (toggling every 3 cycles for 20 cycles) then stable -> exactly one push, code correct, no push during the bounce.
- Rows 0 and 2 both low on col1 -> key_code=1 (lowest row wins).
- Five distinct presses with no key_ack -> codes 1st–4th retained in order, overflow=1; overflow_clr -> 0.
- FIFO full, push and key_ack in the same cycle -> count stays 4, head advances, overflow remains 0.
- nRST pulsed low mid-DEBOUNCE -> col_out=4'b1110, key_valid=0 immediately. With KEYPAD_REPEAT_EN, a 700-cycle hold gives 1 initial + 3 repeat pushes (t=500, 600, 700).
